// File: rtl/pong_pkg.sv
// Shared pong constants: overlay state encoding, frame-tick position,
// seven-segment bit order and centre-net width.
package pong_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    FLASH = 2'd1,
    OVER  = 2'd2
  } state_t;

  // Shared with the ball block so every renderer updates on the same pixel.
  localparam logic [9:0] FRAME_TICK_X = 10'd0;
  localparam logic [9:0] FRAME_TICK_Y = 10'd481;

  // Seven-segment masks are packed {a,b,c,d,e,f,g}, segment a in the MSB.
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam int NET_WIDTH = 4;

  // Half-open interval test: lo <= v < hi.
  function automatic logic in_span(input logic [9:0] v, input logic [9:0] lo,
                                   input logic [9:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit value to seven-segment mask; 10-15 show a dash.
module seg7_decode
  import pong_pkg::*;
(
  input  logic [3:0] i_value,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = '0;
    case (i_value)
      4'd0:    o_seg = 7'b1111110;
      4'd1:    o_seg = 7'b0110000;
      4'd2:    o_seg = 7'b1101101;
      4'd3:    o_seg = 7'b1111001;
      4'd4:    o_seg = 7'b0110011;
      4'd5:    o_seg = 7'b1011011;
      4'd6:    o_seg = 7'b1011111;
      4'd7:    o_seg = 7'b1110000;
      4'd8:    o_seg = 7'b1111111;
      4'd9:    o_seg = 7'b1111011;
      default: o_seg[SEG_G] = 1'b1;
    endcase
  end

endmodule

// File: rtl/score_overlay.sv
// Score overlay: two seven-segment score digits plus dashed centre net, with
// point-scored flashing and a terminal game-over state. RGB is registered.
module score_overlay
  import pong_pkg::*;
#(
  parameter int screen_width  = 640,
  parameter int screen_height = 480,
  parameter int digit1_x      = 256,
  parameter int digit2_x      = 352,
  parameter int digit_y       = 16,
  parameter int seg_len       = 24,
  parameter int seg_thick     = 4,
  parameter int flash_frames  = 60,
  parameter int win_score     = 10
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [9:0] i_pixel_x,
  input  logic [9:0] i_pixel_y,
  input  logic       i_visible_area,
  input  logic [3:0] i_score1,
  input  logic [3:0] i_score2,
  output logic       o_r,
  output logic       o_g,
  output logic       o_b,
  output logic       o_game_over,
  output logic       o_winner,
  output state_t     o_dbg_state
);

  localparam logic [9:0] D1X        = 10'(digit1_x);
  localparam logic [9:0] D2X        = 10'(digit2_x);
  localparam logic [9:0] DY         = 10'(digit_y);
  localparam logic [9:0] L          = 10'(seg_len);
  localparam logic [9:0] T          = 10'(seg_thick);
  localparam logic [9:0] NET_X0     = 10'(screen_width / 2 - NET_WIDTH / 2);
  localparam logic [9:0] NET_X1     = 10'(screen_width / 2 + NET_WIDTH / 2);
  localparam logic [9:0] SCR_H      = 10'(screen_height);
  localparam logic [4:0] WIN        = 5'(win_score);
  localparam logic [5:0] FLASH_LOAD = 6'(flash_frames - 1);

  state_t     state_q, state_d;
  logic [3:0] s1_q, s1_d, s2_q, s2_d;
  logic [5:0] flash_cnt_q, flash_cnt_d;
  logic [5:0] blink_q, blink_d;
  logic [1:0] mask_q, mask_d;
  logic       game_over_q, game_over_d;
  logic       winner_q, winner_d;
  logic       r_q, r_d, g_q, g_d, b_q, b_d;

  logic       frame_tick, win1, win2;
  logic [1:0] chg;
  logic [6:0] seg1, seg2;
  logic       blank1, blank2, lit1, lit2, net;

  // Which segments of a digit at (x0, y0) cover pixel (x, y).
  function automatic logic [6:0] seg_hits(input logic [9:0] x, input logic [9:0] y,
                                          input logic [9:0] x0, input logic [9:0] y0);
    logic [6:0] h;
    h        = '0;
    h[SEG_A] = in_span(x, x0 + T, x0 + T + L) && in_span(y, y0, y0 + T);
    h[SEG_B] = in_span(x, x0 + T + L, x0 + T + T + L) && in_span(y, y0 + T, y0 + T + L);
    h[SEG_C] = in_span(x, x0 + T + L, x0 + T + T + L)
               && in_span(y, y0 + T + T + L, y0 + T + T + L + L);
    h[SEG_D] = in_span(x, x0 + T, x0 + T + L)
               && in_span(y, y0 + T + T + L + L, y0 + T + T + T + L + L);
    h[SEG_E] = in_span(x, x0, x0 + T) && in_span(y, y0 + T + T + L, y0 + T + T + L + L);
    h[SEG_F] = in_span(x, x0, x0 + T) && in_span(y, y0 + T, y0 + T + L);
    h[SEG_G] = in_span(x, x0 + T, x0 + T + L) && in_span(y, y0 + T + L, y0 + T + T + L);
    return h;
  endfunction

  seg7_decode u_dec1 (.i_value(s1_q), .o_seg(seg1));
  seg7_decode u_dec2 (.i_value(s2_q), .o_seg(seg2));

  assign frame_tick = (i_pixel_x == FRAME_TICK_X) && (i_pixel_y == FRAME_TICK_Y);
  assign win1       = {1'b0, i_score1} >= WIN;
  assign win2       = {1'b0, i_score2} >= WIN;
  assign chg        = {i_score2 != s2_q, i_score1 != s1_q};

  always_comb begin
    state_d     = state_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    flash_cnt_d = flash_cnt_q;
    blink_d     = blink_q;
    mask_d      = mask_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    if (frame_tick) begin
      s1_d    = i_score1;
      s2_d    = i_score2;
      blink_d = blink_q + 6'd1;
      // OVER ignores everything; the winner is fixed at the moment of entry.
      if (state_q != OVER) begin
        if (win1 || win2) begin
          state_d     = OVER;
          game_over_d = 1'b1;
          winner_d    = win2 && !win1;
          mask_d      = '0;
          flash_cnt_d = '0;
        end else if (state_q == PLAY) begin
          if (|chg) begin
            state_d     = FLASH;
            mask_d      = chg;
            flash_cnt_d = FLASH_LOAD;
          end
        end else if (|chg) begin
          mask_d      = mask_q | chg;
          flash_cnt_d = FLASH_LOAD;
        end else if (flash_cnt_q == 6'd0) begin
          state_d = PLAY;
          mask_d  = '0;
        end else begin
          flash_cnt_d = flash_cnt_q - 6'd1;
        end
      end
    end
  end

  // In OVER the winner's digit blinks; otherwise the flash mask decides.
  assign blank1 = blink_q[3] && ((state_q == OVER) ? !winner_q : mask_q[0]);
  assign blank2 = blink_q[3] && ((state_q == OVER) ? winner_q : mask_q[1]);
  assign lit1   = (|(seg_hits(i_pixel_x, i_pixel_y, D1X, DY) & seg1)) && !blank1;
  assign lit2   = (|(seg_hits(i_pixel_x, i_pixel_y, D2X, DY) & seg2)) && !blank2;
  assign net    = in_span(i_pixel_x, NET_X0, NET_X1) && !i_pixel_y[4] && (i_pixel_y < SCR_H);

  always_comb begin
    r_d = i_visible_area && (lit1 || lit2);
    g_d = i_visible_area && (lit1 || lit2 || net);
    b_d = r_d;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= PLAY;
      s1_q        <= '0;
      s2_q        <= '0;
      flash_cnt_q <= '0;
      blink_q     <= '0;
      mask_q      <= '0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
      r_q         <= 1'b0;
      g_q         <= 1'b0;
      b_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      flash_cnt_q <= flash_cnt_d;
      blink_q     <= blink_d;
      mask_q      <= mask_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
    end
  end

  assign o_r         = r_q;
  assign o_g         = g_q;
  assign o_b         = b_q;
  assign o_game_over = game_over_q;
  assign o_winner    = winner_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_score_overlay.sv
// Bench for score_overlay: frame ticks and pixel probes are driven directly,
// and every probe is scored against a frame-level model of the overlay.
module tb_score_overlay;
  import pong_pkg::*;

  // ---- clock / reset ----
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [9:0] px, py;
  logic       vis;
  logic [3:0] score1, score2;
  logic       o_r, o_g, o_b, game_over, winner;
  state_t     dbg_state;

  score_overlay dut (
    .i_clk(clk), .i_reset(rst), .i_pixel_x(px), .i_pixel_y(py),
    .i_visible_area(vis), .i_score1(score1), .i_score2(score2),
    .o_r(o_r), .o_g(o_g), .o_b(o_b), .o_game_over(game_over),
    .o_winner(winner), .o_dbg_state(dbg_state)
  );

  // ---- scoreboard ----
  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---- reference model (one update per frame) ----
  int m_tick, m_s1, m_s2, m_flash_end;
  bit m_over, m_winner, m_flashing;
  bit [1:0] m_mask;

  string seg_tab[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg",
                         "abc", "abcdefg", "abcdfg", "g", "g", "g", "g", "g", "g"};

  task automatic model_reset();
    m_tick = 0; m_s1 = 0; m_s2 = 0; m_flash_end = 0;
    m_over = 0; m_winner = 0; m_flashing = 0; m_mask = 0;
  endtask

  task automatic model_tick(input int n1, input int n2);
    m_tick++;
    if (!m_over) begin
      if (n1 >= 10 || n2 >= 10) begin
        m_over = 1;
        m_winner = (n2 >= 10) && (n1 < 10);
      end else if (n1 != m_s1 || n2 != m_s2) begin
        if (!m_flashing) m_mask = 0;
        m_flashing = 1;
        if (n1 != m_s1) m_mask[0] = 1;
        if (n2 != m_s2) m_mask[1] = 1;
        m_flash_end = m_tick + 60;
      end else if (m_flashing && m_tick >= m_flash_end) begin
        m_flashing = 0;
        m_mask = 0;
      end
    end
    m_s1 = n1;
    m_s2 = n2;
  endtask

  function automatic byte seg_at(input int x, input int y, input int x0, input int y0);
    int dx = x - x0;
    int dy = y - y0;
    int t = 4;
    int l = 24;
    if (dx >= t && dx < t + l) begin
      if (dy >= 0 && dy < t) return "a";
      if (dy >= t + l && dy < 2 * t + l) return "g";
      if (dy >= 2 * t + 2 * l && dy < 3 * t + 2 * l) return "d";
    end else if (dx >= 0 && dx < t) begin
      if (dy >= t && dy < t + l) return "f";
      if (dy >= 2 * t + l && dy < 2 * t + 2 * l) return "e";
    end else if (dx >= t + l && dx < 2 * t + l) begin
      if (dy >= t && dy < t + l) return "b";
      if (dy >= 2 * t + l && dy < 2 * t + 2 * l) return "c";
    end
    return 8'h00;
  endfunction

  function automatic bit digit_lit(input int x, input int y, input int x0, input int val,
                                   input bit blank);
    byte c = seg_at(x, y, x0, 16);
    string s = seg_tab[val];
    if (c == 8'h00 || blank) return 0;
    for (int i = 0; i < s.len(); i++) if (s[i] == c) return 1;
    return 0;
  endfunction

  function automatic logic [2:0] exp_rgb(input int x, input int y, input bit v);
    bit b3 = ((m_tick / 8) % 2) == 1;
    bit bl1 = b3 && (m_over ? !m_winner : (m_flashing && m_mask[0]));
    bit bl2 = b3 && (m_over ? m_winner : (m_flashing && m_mask[1]));
    bit dig = digit_lit(x, y, 256, m_s1, bl1) || digit_lit(x, y, 352, m_s2, bl2);
    bit nt = (x >= 318) && (x < 322) && ((y / 16) % 2 == 0) && (y < 480);
    if (!v) return 3'b000;
    if (dig) return 3'b111;
    if (nt) return 3'b010;
    return 3'b000;
  endfunction

  function automatic state_t exp_state();
    if (m_over) return OVER;
    if (m_flashing) return FLASH;
    return PLAY;
  endfunction

  // ---- driver tasks ----
  task automatic probe(input int x, input int y, input bit v);
    px = 10'(x); py = 10'(y); vis = v;
    exp_q.push_back(32'(exp_rgb(x, y, v)));
    @(posedge clk); #1;
    check($sformatf("rgb(%0d,%0d,v%0d)", x, y, v), 32'({o_r, o_g, o_b}), exp_q.pop_front());
  endtask

  task automatic probe_fixed(input string tag, input int x, input int y, input bit v,
                             input logic [2:0] exp);
    px = 10'(x); py = 10'(y); vis = v;
    @(posedge clk); #1;
    check(tag, 32'({o_r, o_g, o_b}), 32'(exp));
  endtask

  task automatic tick();
    px = 10'd0; py = 10'd481; vis = 1'b0;
    @(posedge clk); #1;
    model_tick(int'(score1), int'(score2));
    check("tick_rgb", 32'({o_r, o_g, o_b}), 32'd0);
    check("state", 32'(dbg_state), 32'(exp_state()));
    check("game_over", 32'(game_over), 32'(m_over));
    if (m_over) check("winner", 32'(winner), 32'(m_winner));
  endtask

  task automatic rand_probes(input int n);
    int x, y;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 3))
        0: begin x = $urandom_range(250, 300); y = $urandom_range(10, 82); end
        1: begin x = $urandom_range(346, 396); y = $urandom_range(10, 82); end
        2: begin x = $urandom_range(312, 328); y = $urandom_range(0, 479); end
        default: begin x = $urandom_range(0, 639); y = $urandom_range(0, 479); end
      endcase
      probe(x, y, $urandom_range(0, 9) != 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rgb", 32'({o_r, o_g, o_b}), 32'd0);
    check("rst_game_over", 32'(game_over), 32'd0);
    check("rst_winner", 32'(winner), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(PLAY));
    rst = 1'b0;
    model_reset();
  endtask

  // ---- stimulus ----
  initial begin
    rst = 1'b1; px = '0; py = '0; vis = 1'b0; score1 = '0; score2 = '0;
    model_reset();
    do_reset();

    tick(); tick();
    probe_fixed("seg_a_d1", 264, 17, 1, 3'b111);
    probe_fixed("seg_f_d1", 256, 40, 1, 3'b111);
    probe_fixed("seg_g_d1", 264, 46, 1, 3'b000);
    check("idle_game_over", 32'(game_over), 32'd0);
    probe_fixed("net_on", 318, 5, 1, 3'b010);
    probe_fixed("net_gap", 318, 20, 1, 3'b000);
    probe_fixed("net_invisible", 318, 5, 0, 3'b000);
    rand_probes(20);

    // Mid-frame score change must not show before the frame tick.
    score1 = 4'd1;
    probe_fixed("no_tearing", 264, 17, 1, 3'b111);
    tick();
    check("flash_entry", 32'(dbg_state), 32'(FLASH));
    for (int i = 0; i < 62; i++) begin
      tick();
      probe(285, 30, 1);
      rand_probes(4);
    end

    score1 = 4'd2; score2 = 4'd3;
    for (int i = 0; i < 64; i++) begin
      tick();
      probe(285, 30, 1);
      probe(381, 30, 1);
      rand_probes(3);
    end

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 99) < 15) begin
        if ($urandom_range(0, 1) == 1) score1 = 4'($urandom_range(0, 9));
        else score2 = 4'($urandom_range(0, 9));
      end
      tick();
      rand_probes(4);
    end

    score1 = 4'd9; score2 = 4'd10;
    tick();
    check("over_game_over", 32'(game_over), 32'd1);
    check("over_winner", 32'(winner), 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      probe(360, 45, 1);
      probe(265, 45, 1);
      rand_probes(2);
    end
    score2 = 4'd0;
    for (int i = 0; i < 20; i++) begin
      tick();
      probe(381, 30, 1);
      rand_probes(2);
    end
    check("over_sticky", 32'(dbg_state), 32'(OVER));

    // Asynchronous reset while flashing, in the middle of a frame.
    do_reset();
    tick();
    check("flash_before_rst", 32'(dbg_state), 32'(FLASH));
    probe_fixed("net_before_rst", 318, 5, 1, 3'b010);
    rst = 1'b1;
    #1;
    check("async_rgb", 32'({o_r, o_g, o_b}), 32'd0);
    check("async_state", 32'(dbg_state), 32'(PLAY));
    check("async_game_over", 32'(game_over), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    probe_fixed("net_after_rst", 318, 5, 1, 3'b010);
    check("state_after_rst", 32'(dbg_state), 32'(PLAY));
    for (int i = 0; i < 12; i++) begin
      tick();
      probe(285, 30, 1);
      rand_probes(3);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
